// File: rtl/irq_cause_collector.sv
// Interrupt cause collector: turns rising edges of io_irq into queued cause codes
// and presents them one at a time to the core over a valid/ready port.
module irq_cause_collector #(
    parameter int CAUSE_W = 6,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               io_irq,
    input  logic [CAUSE_W-1:0] io_irq_cause,
    output logic               io_deq_valid,
    input  logic               io_deq_ready,
    output logic [CAUSE_W-1:0] io_deq_bits,
    output logic [CNT_W-1:0]   io_count,
    output logic               io_overflow,
    input  logic               io_overflow_clr
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [CAUSE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               irq_q;
    logic               overflow;

    logic capture;
    logic deq_fire;
    logic full;
    logic enq_fire;
    logic drop;

    // A full FIFO still accepts a new cause when the head leaves in the same cycle.
    always_comb begin
        capture  = io_irq & ~irq_q;
        deq_fire = io_deq_valid & io_deq_ready;
        full     = (count == CNT_W'(DEPTH));
        enq_fire = capture & (~full | deq_fire);
        drop     = capture & full & ~deq_fire;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            irq_q <= io_irq;
            if (enq_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // A fresh drop takes priority over a clear arriving in the same cycle.
            if (drop) begin
                overflow <= 1'b1;
            end else if (io_overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[wr_ptr] <= io_irq_cause;
        end
    end

    assign io_deq_valid = (count != '0);
    assign io_deq_bits  = io_deq_valid ? mem[rd_ptr] : '0;
    assign io_count     = count;
    assign io_overflow  = overflow;

endmodule

// File: tb/tb_irq_cause_collector.sv
// Scoreboard bench for irq_cause_collector: stimulus pushes expected causes,
// a negedge monitor pops and compares on every accepted handshake.
module tb_irq_cause_collector;

    localparam int CAUSE_W = 6;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               io_irq;
    logic [CAUSE_W-1:0] io_irq_cause;
    logic               io_deq_valid;
    logic               io_deq_ready;
    logic [CAUSE_W-1:0] io_deq_bits;
    logic [CNT_W-1:0]   io_count;
    logic               io_overflow;
    logic               io_overflow_clr;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [CAUSE_W-1:0] exp_q [$];
    int   m_count;
    logic m_irq_q;
    logic m_ovf;

    irq_cause_collector #(.CAUSE_W(CAUSE_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .io_irq          (io_irq),
        .io_irq_cause    (io_irq_cause),
        .io_deq_valid    (io_deq_valid),
        .io_deq_ready    (io_deq_ready),
        .io_deq_bits     (io_deq_bits),
        .io_count        (io_count),
        .io_overflow     (io_overflow),
        .io_overflow_clr (io_overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every accepted head entry must be the oldest cause the model queued.
    always @(negedge clk) begin
        if (reset === 1'b0 && io_deq_valid === 1'b1 && io_deq_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL deq_unexpected: got %0h expected no entry", io_deq_bits);
            end else begin
                check("deq_bits", io_deq_bits, exp_q.pop_front());
            end
        end
    end

    task automatic model_reset();
        m_count = 0;
        m_irq_q = 1'b0;
        m_ovf   = 1'b0;
        exp_q.delete();
    endtask

    // One clock: drive inputs, compare pre-edge state, then advance the model at the edge.
    task automatic step(input logic irq, input logic [CAUSE_W-1:0] cause,
                        input logic rdy, input logic clr);
        bit cap, deq, enq, drop;
        io_irq          = irq;
        io_irq_cause    = cause;
        io_deq_ready    = rdy;
        io_overflow_clr = clr;
        @(negedge clk);
        check("count", io_count, m_count);
        check("valid", io_deq_valid, (m_count != 0));
        check("overflow", io_overflow, m_ovf);
        cap  = irq && !m_irq_q;
        deq  = (m_count != 0) && rdy;
        enq  = cap && (m_count < DEPTH || deq);
        drop = cap && !enq;
        @(posedge clk);
        m_irq_q = irq;
        if (enq) exp_q.push_back(cause);
        m_count = m_count + int'(enq) - int'(deq);
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        #1;
    endtask

    task automatic pulse(input logic [CAUSE_W-1:0] cause);
        step(1'b1, cause, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish expected finish before time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b1;
        io_irq = 1'b0; io_irq_cause = '0; io_deq_ready = 1'b0; io_overflow_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        check("rst_valid", io_deq_valid, 0);
        check("rst_bits", io_deq_bits, 0);
        check("rst_count", io_count, 0);
        check("rst_overflow", io_overflow, 0);
        #1 reset = 1'b0;

        // Single capture with one-cycle latency, held level does not recapture.
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 6'h22, 1'b0, 1'b0);
        check("t1_valid", io_deq_valid, 1);
        check("t1_bits", io_deq_bits, 6'h22);
        check("t1_count", io_count, 1);
        repeat (10) step(1'b1, 6'h3F, 1'b0, 1'b0);
        check("t1_hold_count", io_count, 1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("t1_drained", io_count, 0);

        // Fill, overflow on the fifth cause, drain in order.
        pulse(6'h21); pulse(6'h22); pulse(6'h23); pulse(6'h24);
        check("t2_full", io_count, 4);
        pulse(6'h25);
        check("t2_count", io_count, 4);
        check("t2_overflow", io_overflow, 1);
        check("t2_head", io_deq_bits, 6'h21);
        repeat (4) step(1'b0, '0, 1'b1, 1'b0);
        check("t2_empty", io_count, 0);
        check("t2_sb_empty", exp_q.size(), 0);

        // Clear alone, then clear coinciding with a drop.
        step(1'b0, '0, 1'b0, 1'b1);
        check("t4_clr", io_overflow, 0);
        pulse(6'h26); pulse(6'h27); pulse(6'h28); pulse(6'h29);
        step(1'b1, 6'h30, 1'b0, 1'b1);
        check("t4_clr_vs_drop", io_overflow, 1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("t4_clr2", io_overflow, 0);

        // Full FIFO: capture and dequeue together.
        step(1'b1, 6'h2A, 1'b1, 1'b0);
        check("t3_count", io_count, 4);
        check("t3_overflow", io_overflow, 0);
        check("t3_head", io_deq_bits, 6'h27);
        repeat (4) step(1'b0, '0, 1'b1, 1'b0);
        check("t3_empty", io_count, 0);
        check("t3_sb_empty", exp_q.size(), 0);

        // Asynchronous reset mid-operation, then release with io_irq high.
        pulse(6'h11); pulse(6'h12); pulse(6'h13); pulse(6'h14); pulse(6'h15);
        check("t5_ovf_before", io_overflow, 1);
        #2 reset = 1'b1;
        #1;
        check("t5_async_valid", io_deq_valid, 0);
        check("t5_async_count", io_count, 0);
        check("t5_async_overflow", io_overflow, 0);
        check("t5_async_bits", io_deq_bits, 0);
        model_reset();
        io_irq = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) step(1'b1, 6'h1C, 1'b0, 1'b0);
        check("t5_one_capture", io_count, 1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("t5_drained", io_count, 0);

        // Random traffic against the model.
        for (int i = 0; i < 1000; i++) begin
            step(1'($urandom_range(0, 1)), CAUSE_W'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
        end
        check("t6_empty", io_count, 0);
        check("t6_sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
